// File: rtl/fold_scheduler_pkg.sv
// Shared types and default sizing for the folded HDC scheduler.
// Default channel sizing stands in for the global channel-count macros.
package fold_scheduler_pkg;

  localparam int TOTAL_NUM_CHANNEL     = 64;
  localparam int MAX_NUM_CHANNEL_WIDTH = 6;
  localparam int DEF_NUM_FOLDS         = 100;
  localparam int DEF_NUM_FOLDS_WIDTH   = 7;
  localparam int DEF_NUM_WINDOWS       = 3;
  localparam int CLS_WIDTH             = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_FOLD} sched_state_t;

  typedef logic [DEF_NUM_FOLDS_WIDTH-1:0]   fold_idx_t;
  typedef logic [MAX_NUM_CHANNEL_WIDTH-1:0] chan_idx_t;

endpackage

// File: rtl/fold_scheduler_wrap_counter.sv
// Modulo-MAX counter with synchronous clear; at_max flags the last value.
// Clear wins over increment; increment at the last value wraps to zero.
module fold_scheduler_wrap_counter #(
  parameter int MAX   = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             at_max
);

  assign at_max = (value == WIDTH'(MAX - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= at_max ? '0 : value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fold_scheduler.sv
// Walks every (fold, channel) step of one feature frame, holding each new fold
// until the datapath reports the previous one drained; tracks the classification window.
module fold_scheduler
  import fold_scheduler_pkg::*;
#(
  parameter int NUM_FOLDS       = DEF_NUM_FOLDS,
  parameter int NUM_FOLDS_WIDTH = DEF_NUM_FOLDS_WIDTH,
  parameter int NUM_CHANNEL     = TOTAL_NUM_CHANNEL,
  parameter int CHAN_WIDTH      = MAX_NUM_CHANNEL_WIDTH,
  parameter int NUM_WINDOWS     = DEF_NUM_WINDOWS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fin_valid,
  output logic                       fin_ready,
  output logic                       step_valid,
  input  logic                       step_ready,
  output logic [NUM_FOLDS_WIDTH-1:0] fold_idx,
  output logic [CHAN_WIDTH-1:0]      chan_idx,
  output logic                       first_chan,
  output logic                       last_chan,
  output logic                       last_fold,
  input  logic                       fold_done,
  output logic [CLS_WIDTH-1:0]       classification_counter,
  output logic                       send_to_am,
  output logic                       busy
);

  sched_state_t         state;
  logic                 accept, retire, drain;
  logic                 chan_at_max, fold_at_max, cls_at_max;
  logic [CLS_WIDTH-1:0] cls_next;

  assign accept = (state == IDLE) && fin_valid && fin_ready;
  assign retire = (state == ISSUE) && step_valid && step_ready;
  // fold_done is only meaningful while draining; elsewhere it is ignored
  assign drain  = (state == WAIT_FOLD) && fold_done;

  fold_scheduler_wrap_counter #(.MAX(NUM_CHANNEL), .WIDTH(CHAN_WIDTH)) u_chan_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (retire && !chan_at_max),
    .clr    (accept || drain),
    .value  (chan_idx),
    .at_max (chan_at_max)
  );

  fold_scheduler_wrap_counter #(.MAX(NUM_FOLDS), .WIDTH(NUM_FOLDS_WIDTH)) u_fold_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (drain),
    .clr    (accept),
    .value  (fold_idx),
    .at_max (fold_at_max)
  );

  fold_scheduler_wrap_counter #(.MAX(NUM_WINDOWS), .WIDTH(CLS_WIDTH)) u_cls_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (drain && fold_at_max),
    .clr    (1'b0),
    .value  (classification_counter),
    .at_max (cls_at_max)
  );

  assign cls_next   = cls_at_max ? '0 : classification_counter + CLS_WIDTH'(1);
  assign first_chan = (chan_idx == '0);
  assign last_chan  = chan_at_max;
  assign last_fold  = fold_at_max;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      step_valid <= 1'b0;
      fin_ready  <= 1'b1;
      busy       <= 1'b0;
      send_to_am <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= ISSUE;
            step_valid <= 1'b1;
            fin_ready  <= 1'b0;
            busy       <= 1'b1;
          end
        end
        ISSUE: begin
          if (retire && chan_at_max) begin
            state      <= WAIT_FOLD;
            step_valid <= 1'b0;
          end
        end
        WAIT_FOLD: begin
          if (drain) begin
            if (fold_at_max) begin
              state      <= IDLE;
              fin_ready  <= 1'b1;
              busy       <= 1'b0;
              // tracks the counter so it changes on the same edge as the wrap
              send_to_am <= (cls_next == CLS_WIDTH'(NUM_WINDOWS - 1));
            end else begin
              state      <= ISSUE;
              step_valid <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          step_valid <= 1'b0;
          fin_ready  <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fold_scheduler.sv
// Directed bench for fold_scheduler with 4 folds x 3 channels and 3 windows.
// Inputs change and outputs are sampled on the falling edge.
module tb_fold_scheduler;

  localparam int NF  = 4;
  localparam int NFW = 2;
  localparam int NC  = 3;
  localparam int CW  = 2;
  localparam int NW  = 3;

  logic           clk;
  logic           rst;
  logic           fin_valid, fin_ready;
  logic           step_valid, step_ready;
  logic [NFW-1:0] fold_idx;
  logic [CW-1:0]  chan_idx;
  logic           first_chan, last_chan, last_fold;
  logic           fold_done;
  logic [1:0]     classification_counter;
  logic           send_to_am, busy;

  int errors = 0;
  int checks = 0;
  int model_cc = 0;
  int viol_cnt = 0;
  int hs_cnt = 0;
  bit bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  fold_scheduler #(
    .NUM_FOLDS(NF), .NUM_FOLDS_WIDTH(NFW), .NUM_CHANNEL(NC), .CHAN_WIDTH(CW), .NUM_WINDOWS(NW)
  ) dut (
    .clk(clk), .rst(rst), .fin_valid(fin_valid), .fin_ready(fin_ready),
    .step_valid(step_valid), .step_ready(step_ready), .fold_idx(fold_idx), .chan_idx(chan_idx),
    .first_chan(first_chan), .last_chan(last_chan), .last_fold(last_fold), .fold_done(fold_done),
    .classification_counter(classification_counter), .send_to_am(send_to_am), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol monitor: fold_done is only legal while the scheduler waits for a drain.
  always @(posedge clk) begin
    if (rst && fold_done && !(busy && !step_valid)) viol_cnt++;
    if (rst && fin_valid && fin_ready) hs_cnt++;
  end

  task automatic do_reset();
    rst = 1'b0; fin_valid = 1'b0; step_ready = 1'b0; fold_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_cc = 0;
    @(negedge clk);
  endtask

  // Runs one frame against an in-order step model; lat counts the handshake edge as cycle 1.
  task automatic run_frame(input bit bp, input bit hold_fin, input int stop_f, input int stop_c,
                           output int steps, output int lat);
    int ef, ec, wait_cnt, bp_i, guard;
    bit done;
    steps = 0; lat = 0; ef = 0; ec = 0; wait_cnt = 0; bp_i = 0; guard = 0; done = 1'b0;
    while (!fin_ready && guard < 50) begin @(negedge clk); guard++; end
    checks++;
    if (fin_ready !== 1'b1) begin errors++; $display("FAIL frame_start_ready: got %b want 1", fin_ready); end
    fin_valid = 1'b1; step_ready = 1'b1;
    @(negedge clk);
    if (!hold_fin) fin_valid = 1'b0;
    lat = 1;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (fin_ready && !busy) begin
        done = 1'b1;
      end else begin
        checks++;
        if (classification_counter !== 2'(model_cc) || send_to_am !== (model_cc == NW - 1)) begin
          errors++;
          $display("FAIL cc_in_frame: got cc=%0d send=%b want cc=%0d send=%b",
                   classification_counter, send_to_am, model_cc, (model_cc == NW - 1));
        end
        if (step_valid) begin
          wait_cnt = 0;
          checks++;
          if (fold_idx !== NFW'(ef) || chan_idx !== CW'(ec)) begin
            errors++;
            $display("FAIL step_order: got f%0d c%0d want f%0d c%0d", fold_idx, chan_idx, ef, ec);
          end
          checks++;
          if (first_chan !== (ec == 0) || last_chan !== (ec == NC - 1) || last_fold !== (ef == NF - 1)) begin
            errors++;
            $display("FAIL step_flags f%0d c%0d: got first=%b last_c=%b last_f=%b want %b %b %b",
                     ef, ec, first_chan, last_chan, last_fold, (ec == 0), (ec == NC - 1), (ef == NF - 1));
          end
          if (ef == stop_f && ec == stop_c) return;
          if (bp && ef == 1) begin
            step_ready = bp_pat[bp_i % 4];
            bp_i++;
          end else begin
            step_ready = 1'b1;
          end
          if (step_ready) begin
            steps++;
            if (ec < NC - 1) ec++;
          end
        end else begin
          wait_cnt++;
          fold_done = (wait_cnt == 2);
          if (wait_cnt == 2 && ef < NF - 1) begin ef++; ec = 0; end
        end
        @(negedge clk);
        fold_done = 1'b0;
        lat++;
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL frame_timeout: got busy=%b want idle", busy); end
    model_cc = (model_cc + 1) % NW;
    checks++;
    if (classification_counter !== 2'(model_cc) || send_to_am !== (model_cc == NW - 1)) begin
      errors++;
      $display("FAIL cc_after_frame: got cc=%0d send=%b want cc=%0d send=%b",
               classification_counter, send_to_am, model_cc, (model_cc == NW - 1));
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({fin_ready, step_valid, busy} !== 3'b100) begin
      errors++; $display("FAIL reset_hs: got rdy/vld/busy=%b want 100", {fin_ready, step_valid, busy});
    end
    checks++;
    if ({first_chan, last_chan, last_fold, send_to_am} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags: got %b want 1000", {first_chan, last_chan, last_fold, send_to_am});
    end
    checks++;
    if (fold_idx !== '0 || chan_idx !== '0 || classification_counter !== 2'd0) begin
      errors++; $display("FAIL reset_idx: got f%0d c%0d cc%0d want 0 0 0", fold_idx, chan_idx, classification_counter);
    end
  endtask

  task automatic test_basic_frame();
    int steps, lat;
    do_reset();
    run_frame(1'b0, 1'b0, -1, -1, steps, lat);
    checks++;
    if (steps !== NC * NF) begin errors++; $display("FAIL basic_steps: got %0d want %0d", steps, NC * NF); end
    checks++;
    if (lat !== 21) begin errors++; $display("FAIL basic_latency: got %0d want 21", lat); end
  endtask

  task automatic test_backpressure();
    int steps, lat;
    run_frame(1'b1, 1'b0, -1, -1, steps, lat);
    checks++;
    if (steps !== 12) begin errors++; $display("FAIL bp_steps: got %0d want 12", steps); end
    checks++;
    if (lat !== 23) begin errors++; $display("FAIL bp_latency: got %0d want 23", lat); end
  endtask

  task automatic test_window_wrap();
    int steps, lat;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (classification_counter !== 2'(i) || send_to_am !== (i == 2)) begin
        errors++;
        $display("FAIL wrap_frame%0d: got cc=%0d send=%b want cc=%0d send=%b",
                 i, classification_counter, send_to_am, i, (i == 2));
      end
      run_frame(1'b0, 1'b0, -1, -1, steps, lat);
    end
    checks++;
    if (classification_counter !== 2'd0) begin
      errors++; $display("FAIL wrap_final: got %0d want 0", classification_counter);
    end
  endtask

  task automatic test_spurious_fold_done();
    int v0;
    do_reset();
    v0 = viol_cnt;
    fold_done = 1'b1;
    @(negedge clk);
    fold_done = 1'b0;
    checks++;
    if ({fin_ready, busy, step_valid} !== 3'b100 || fold_idx !== '0) begin
      errors++; $display("FAIL spur_idle: got rdy/busy/vld=%b f%0d want 100 f0", {fin_ready, busy, step_valid}, fold_idx);
    end
    fin_valid = 1'b1; step_ready = 1'b1;
    @(negedge clk);
    fin_valid = 1'b0;
    @(negedge clk);
    step_ready = 1'b0; fold_done = 1'b1;
    @(negedge clk);
    fold_done = 1'b0;
    checks++;
    if (fold_idx !== '0 || chan_idx !== 2'd1 || step_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL spur_issue: got f%0d c%0d vld=%b want f0 c1 vld=1", fold_idx, chan_idx, step_valid);
    end
    checks++;
    if (viol_cnt - v0 !== 2) begin errors++; $display("FAIL spur_assert: got %0d flags want 2", viol_cnt - v0); end
    do_reset();
  endtask

  task automatic test_reset_mid_frame();
    int steps, lat;
    do_reset();
    run_frame(1'b0, 1'b0, -1, -1, steps, lat);
    run_frame(1'b0, 1'b0, 2, 1, steps, lat);
    checks++;
    if (fold_idx !== 2'd2 || chan_idx !== 2'd1 || classification_counter !== 2'd1) begin
      errors++; $display("FAIL mid_pre: got f%0d c%0d cc%0d want f2 c1 cc1", fold_idx, chan_idx, classification_counter);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({step_valid, fin_ready, busy, send_to_am} !== 4'b0100) begin
      errors++; $display("FAIL mid_ctrl: got vld/rdy/busy/send=%b want 0100", {step_valid, fin_ready, busy, send_to_am});
    end
    checks++;
    if (fold_idx !== '0 || chan_idx !== '0 || classification_counter !== 2'd0) begin
      errors++; $display("FAIL mid_idx: got f%0d c%0d cc%0d want 0 0 0", fold_idx, chan_idx, classification_counter);
    end
    model_cc = 0;
    fin_valid = 1'b0; step_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_frame(1'b0, 1'b0, -1, -1, steps, lat);
    checks++;
    if (steps !== 12) begin errors++; $display("FAIL mid_recover: got %0d steps want 12", steps); end
  endtask

  task automatic test_busy_ignore();
    int steps, lat, h0;
    do_reset();
    h0 = hs_cnt;
    run_frame(1'b0, 1'b1, -1, -1, steps, lat);
    checks++;
    if (hs_cnt - h0 !== 1) begin errors++; $display("FAIL busy_one_frame: got %0d handshakes want 1", hs_cnt - h0); end
    @(negedge clk);
    checks++;
    if (hs_cnt - h0 !== 2 || busy !== 1'b1 || fin_ready !== 1'b0) begin
      errors++; $display("FAIL busy_rehandshake: got hs=%0d busy=%b want hs=2 busy=1", hs_cnt - h0, busy);
    end
    fin_valid = 1'b0;
    do_reset();
  endtask

  initial begin
    rst = 1'b0; fin_valid = 1'b0; step_ready = 1'b0; fold_done = 1'b0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_window_wrap();
    test_spurious_fold_done();
    test_reset_mid_frame();
    test_busy_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
